alu_op_sequencer: RTL and testbench



---
 rtl/alu_op_sequencer.sv | 128 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Initiator side of an 8-bit ALU operand/result interface: accepts commands,
// holds operands for a fixed ALU latency, captures the result and returns it.
module alu_op_sequencer #(
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [7:0]  CMD_A,
  input  logic [7:0]  CMD_B,
  input  logic [7:0]  CMD_OPCODE,
  input  logic        CMD_CHAIN,
  output logic [7:0]  OP_A,
  output logic [7:0]  OP_B,
  output logic [7:0]  OPCODE,
  input  logic [7:0]  ALU_OUT,
  input  logic        CARRY,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [7:0]  RSP_DATA,
  output logic        RSP_CARRY,
  output logic        BUSY,
  output logic [15:0] OP_COUNT
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_t;

  localparam logic [3:0] LAT = 4'(ALU_LATENCY);

  state_t      state;
  state_t      next_state;
  logic [3:0]  cnt;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [7:0]  opcode;
  logic [7:0]  acc;
  logic [7:0]  rsp_data;
  logic        rsp_carry;
  logic        rsp_valid;
  logic        busy;
  logic [15:0] op_count;
  logic        accept;
  logic        capture;
  logic        rsp_done;

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    capture    = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      IDLE: begin
        if (CMD_VALID) begin
          accept     = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          capture    = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (RSP_READY) begin
          rsp_done   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand lines are only ever rewritten on acceptance, so the ALU sees
  // stable inputs for the whole operation and between operations.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cnt       <= 4'd0;
      op_a      <= 8'h00;
      op_b      <= 8'h00;
      opcode    <= 8'h00;
      acc       <= 8'h00;
      rsp_data  <= 8'h00;
      rsp_carry <= 1'b0;
      rsp_valid <= 1'b0;
      op_count  <= 16'h0000;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      if (accept) begin
        op_a   <= CMD_CHAIN ? acc : CMD_A;
        op_b   <= CMD_B;
        opcode <= CMD_OPCODE;
        cnt    <= LAT;
      end else if (state == WAIT && !capture) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        rsp_data  <= ALU_OUT;
        rsp_carry <= CARRY;
        acc       <= ALU_OUT;
        rsp_valid <= 1'b1;
      end
      if (rsp_done) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + 16'd1;
      end
    end
  end

  assign CMD_READY = (state == IDLE);
  assign BUSY      = busy;
  assign OP_A      = op_a;
  assign OP_B      = op_b;
  assign OPCODE    = opcode;
  assign RSP_VALID = rsp_valid;
  assign RSP_DATA  = rsp_data;
  assign RSP_CARRY = rsp_carry;
  assign OP_COUNT  = op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: three instances (ALU latency 0, 1, 4),
// each with an adder ALU model, driven from a vector table plus corner sequences.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid [3];
  logic        cmd_ready [3];
  logic [7:0]  cmd_a     [3];
  logic [7:0]  cmd_b     [3];
  logic [7:0]  cmd_opc   [3];
  logic        cmd_chain [3];
  logic [7:0]  op_a      [3];
  logic [7:0]  op_b      [3];
  logic [7:0]  opcode    [3];
  logic [7:0]  alu_out   [3];
  logic        carry     [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [7:0]  rsp_data  [3];
  logic        rsp_carry [3];
  logic        busy      [3];
  logic [15:0] op_count  [3];
  logic [15:0] exp_count [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.ALU_LATENCY(0)) dut0 (
    .CLK(clk), .RESET(reset), .CMD_VALID(cmd_valid[0]), .CMD_READY(cmd_ready[0]),
    .CMD_A(cmd_a[0]), .CMD_B(cmd_b[0]), .CMD_OPCODE(cmd_opc[0]), .CMD_CHAIN(cmd_chain[0]),
    .OP_A(op_a[0]), .OP_B(op_b[0]), .OPCODE(opcode[0]), .ALU_OUT(alu_out[0]), .CARRY(carry[0]),
    .RSP_VALID(rsp_valid[0]), .RSP_READY(rsp_ready[0]), .RSP_DATA(rsp_data[0]),
    .RSP_CARRY(rsp_carry[0]), .BUSY(busy[0]), .OP_COUNT(op_count[0]));

  alu_op_sequencer #(.ALU_LATENCY(1)) dut1 (
    .CLK(clk), .RESET(reset), .CMD_VALID(cmd_valid[1]), .CMD_READY(cmd_ready[1]),
    .CMD_A(cmd_a[1]), .CMD_B(cmd_b[1]), .CMD_OPCODE(cmd_opc[1]), .CMD_CHAIN(cmd_chain[1]),
    .OP_A(op_a[1]), .OP_B(op_b[1]), .OPCODE(opcode[1]), .ALU_OUT(alu_out[1]), .CARRY(carry[1]),
    .RSP_VALID(rsp_valid[1]), .RSP_READY(rsp_ready[1]), .RSP_DATA(rsp_data[1]),
    .RSP_CARRY(rsp_carry[1]), .BUSY(busy[1]), .OP_COUNT(op_count[1]));

  alu_op_sequencer #(.ALU_LATENCY(4)) dut4 (
    .CLK(clk), .RESET(reset), .CMD_VALID(cmd_valid[2]), .CMD_READY(cmd_ready[2]),
    .CMD_A(cmd_a[2]), .CMD_B(cmd_b[2]), .CMD_OPCODE(cmd_opc[2]), .CMD_CHAIN(cmd_chain[2]),
    .OP_A(op_a[2]), .OP_B(op_b[2]), .OPCODE(opcode[2]), .ALU_OUT(alu_out[2]), .CARRY(carry[2]),
    .RSP_VALID(rsp_valid[2]), .RSP_READY(rsp_ready[2]), .RSP_DATA(rsp_data[2]),
    .RSP_CARRY(rsp_carry[2]), .BUSY(busy[2]), .OP_COUNT(op_count[2]));

  // Adder ALU models: combinational, one register stage, four register stages.
  logic [8:0] pipe1;
  logic [8:0] pipe4 [4];

  always_ff @(posedge clk) begin
    pipe1    <= {1'b0, op_a[1]} + {1'b0, op_b[1]};
    pipe4[0] <= {1'b0, op_a[2]} + {1'b0, op_b[2]};
    pipe4[1] <= pipe4[0];
    pipe4[2] <= pipe4[1];
    pipe4[3] <= pipe4[2];
  end

  assign {carry[0], alu_out[0]} = {1'b0, op_a[0]} + {1'b0, op_b[0]};
  assign {carry[1], alu_out[1]} = pipe1;
  assign {carry[2], alu_out[2]} = pipe4[3];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] opc;
    logic       chain;
    logic [7:0] exp_opa;
    logic [7:0] exp_data;
    logic       exp_carry;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // One full operation on instance d with RSP_READY held high.
  task automatic applyStimulus(input int d, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] opc, input logic chain,
                               input logic [7:0] exp_opa, input logic [7:0] exp_data,
                               input logic exp_carry, input int lat, input string name);
    int n;
    @(negedge clk);
    checkOutput({name, ".cmd_ready"}, 16'(cmd_ready[d]), 16'h1);
    cmd_a[d]     = a;
    cmd_b[d]     = b;
    cmd_opc[d]   = opc;
    cmd_chain[d] = chain;
    cmd_valid[d] = 1'b1;
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    cmd_valid[d] = 1'b0;
    checkOutput({name, ".busy"}, 16'(busy[d]), 16'h1);
    checkOutput({name, ".op_a"}, 16'(op_a[d]), 16'(exp_opa));
    checkOutput({name, ".op_b"}, 16'(op_b[d]), 16'(b));
    checkOutput({name, ".opcode"}, 16'(opcode[d]), 16'(opc));
    n = 0;
    while (rsp_valid[d] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, ".latency"}, 16'(n), 16'(lat + 1));
    checkOutput({name, ".rsp_data"}, 16'(rsp_data[d]), 16'(exp_data));
    checkOutput({name, ".rsp_carry"}, 16'(rsp_carry[d]), 16'(exp_carry));
    @(negedge clk);
    exp_count[d] = exp_count[d] + 16'd1;
    checkOutput({name, ".rsp_valid_drop"}, 16'(rsp_valid[d]), 16'h0);
    checkOutput({name, ".op_count"}, op_count[d], exp_count[d]);
    checkOutput({name, ".ready_again"}, 16'(cmd_ready[d]), 16'h1);
  endtask

  task automatic waitResponse(input int d, input string name);
    int n;
    n = 0;
    while (rsp_valid[d] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, ".rsp_seen"}, 16'(rsp_valid[d]), 16'h1);
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, ".rsp_valid"}, 16'(rsp_valid[1]), 16'h0);
    checkOutput({name, ".op_a"}, 16'(op_a[1]), 16'h00);
    checkOutput({name, ".op_count"}, op_count[1], 16'h0000);
    checkOutput({name, ".cmd_ready"}, 16'(cmd_ready[1]), 16'h1);
    checkOutput({name, ".busy"}, 16'(busy[1]), 16'h0);
    checkOutput({name, ".rsp_data"}, 16'(rsp_data[1]), 16'h00);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{8'h12, 8'h34, 8'h05, 1'b0, 8'h12, 8'h46, 1'b0};
    vecs[1] = '{8'hF0, 8'h20, 8'h06, 1'b0, 8'hF0, 8'h10, 1'b1};
    vecs[2] = '{8'h99, 8'h01, 8'h07, 1'b1, 8'h10, 8'h11, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 8'h08, 1'b1, 8'h11, 8'h10, 1'b1};
    vecs[4] = '{8'hFF, 8'h01, 8'h09, 1'b0, 8'hFF, 8'h00, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[6] = '{8'h3C, 8'h7F, 8'h0A, 1'b1, 8'h00, 8'h7F, 1'b0};
    vecs[7] = '{8'h80, 8'h80, 8'hFF, 1'b0, 8'h80, 8'h00, 1'b1};

    for (int d = 0; d < 3; d++) begin
      cmd_valid[d] = 1'b0;
      cmd_a[d]     = 8'h00;
      cmd_b[d]     = 8'h00;
      cmd_opc[d]   = 8'h00;
      cmd_chain[d] = 1'b0;
      rsp_ready[d] = 1'b0;
      exp_count[d] = 16'h0000;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkResetState("reset");
    checkOutput("reset.opcode", 16'(opcode[1]), 16'h00);
    checkOutput("reset.rsp_carry", 16'(rsp_carry[1]), 16'h0);

    // Table-driven ops on the latency-1 instance; accumulator carries across rows.
    for (int i = 0; i < 8; i++)
      applyStimulus(1, vecs[i].a, vecs[i].b, vecs[i].opc, vecs[i].chain,
                    vecs[i].exp_opa, vecs[i].exp_data, vecs[i].exp_carry, 1,
                    $sformatf("vec%0d", i));

    applyStimulus(0, 8'h12, 8'h34, 8'h05, 1'b0, 8'h12, 8'h46, 1'b0, 0, "lat0");
    applyStimulus(0, 8'h00, 8'h01, 8'h05, 1'b1, 8'h46, 8'h47, 1'b0, 0, "lat0_chain");
    applyStimulus(2, 8'hF0, 8'h20, 8'h0C, 1'b0, 8'hF0, 8'h10, 1'b1, 4, "lat4");
    applyStimulus(2, 8'h00, 8'hF0, 8'h0D, 1'b1, 8'h10, 8'h00, 1'b1, 4, "lat4_chain");

    // Backpressure with a second command waiting.
    @(negedge clk);
    cmd_a[1] = 8'h55; cmd_b[1] = 8'h22; cmd_opc[1] = 8'h11; cmd_chain[1] = 1'b0;
    cmd_valid[1] = 1'b1;
    rsp_ready[1] = 1'b0;
    @(negedge clk);
    cmd_a[1] = 8'h01; cmd_b[1] = 8'h02; cmd_opc[1] = 8'h33;
    waitResponse(1, "bp");
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp.hold_valid%0d", i), 16'(rsp_valid[1]), 16'h1);
      checkOutput($sformatf("bp.hold_data%0d", i), 16'(rsp_data[1]), 16'h77);
      checkOutput($sformatf("bp.hold_ready%0d", i), 16'(cmd_ready[1]), 16'h0);
      @(negedge clk);
    end
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    exp_count[1] = exp_count[1] + 16'd1;
    checkOutput("bp.drop", 16'(rsp_valid[1]), 16'h0);
    checkOutput("bp.count", op_count[1], exp_count[1]);
    checkOutput("bp.ready", 16'(cmd_ready[1]), 16'h1);
    @(negedge clk);
    cmd_valid[1] = 1'b0;
    checkOutput("bp.next_busy", 16'(busy[1]), 16'h1);
    checkOutput("bp.next_op_a", 16'(op_a[1]), 16'h01);
    checkOutput("bp.next_opcode", 16'(opcode[1]), 16'h33);
    waitResponse(1, "bp2");
    checkOutput("bp2.data", 16'(rsp_data[1]), 16'h03);
    @(negedge clk);
    exp_count[1] = exp_count[1] + 16'd1;
    checkOutput("bp2.count", op_count[1], exp_count[1]);

    // Reset while waiting on the ALU.
    cmd_a[1] = 8'h40; cmd_b[1] = 8'h40; cmd_chain[1] = 1'b0;
    cmd_valid[1] = 1'b1;
    rsp_ready[1] = 1'b0;
    @(negedge clk);
    cmd_valid[1] = 1'b0;
    checkOutput("rst_wait.busy_before", 16'(busy[1]), 16'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 3; d++) exp_count[d] = 16'h0000;
    checkResetState("rst_wait");

    // Reset in HOLD wins over a simultaneous response handshake.
    cmd_valid[1] = 1'b1;
    @(negedge clk);
    cmd_valid[1] = 1'b0;
    waitResponse(1, "rst_hold");
    rsp_ready[1] = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkResetState("rst_hold");
    applyStimulus(1, 8'hAA, 8'h09, 8'h01, 1'b1, 8'h00, 8'h09, 1'b0, 1, "chain_after_reset");

    // Counter wrap.
    @(negedge clk);
    force dut1.op_count = 16'hFFFF;
    #1;
    release dut1.op_count;
    @(negedge clk);
    checkOutput("wrap.preload", op_count[1], 16'hFFFF);
    exp_count[1] = 16'hFFFF;
    applyStimulus(1, 8'h21, 8'h12, 8'h02, 1'b0, 8'h21, 8'h33, 1'b0, 1, "wrap");
    checkOutput("wrap.zero", op_count[1], 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
